// File: rtl/vga_stream_gen_pkg.sv
// Shared stream-word layout and default 640x480@60 timing for every stage
// that produces or consumes the 26-bit RGB stream.
package vga_stream_gen_pkg;

    localparam int unsigned STREAM_W  = 26;
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned MAX_TOTAL = 1024;

    // Stream field positions
    localparam int unsigned ACTIVE_BIT = 0;
    localparam int unsigned VS_BIT     = 1;
    localparam int unsigned HS_BIT     = 2;
    localparam int unsigned YC_LSB     = 3;
    localparam int unsigned YC_MSB     = 12;
    localparam int unsigned XC_LSB     = 13;
    localparam int unsigned XC_MSB     = 22;
    localparam int unsigned R_BIT      = 23;
    localparam int unsigned G_BIT      = 24;
    localparam int unsigned B_BIT      = 25;
    localparam int unsigned RGB_LSB    = 23;
    localparam int unsigned RGB_MSB    = 25;
    // Raw video control group: Active, VS, HS
    localparam int unsigned VGA_LSB    = 0;
    localparam int unsigned VGA_MSB    = 2;

    // Default 640x480@60 timing
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef logic [COORD_W-1:0] coord_t;
    // One bit wider so window bounds equal to MAX_TOTAL stay representable
    typedef logic [COORD_W:0]   wcoord_t;

    // Assemble one stream word from its fields
    function automatic logic [STREAM_W-1:0] pack_stream(
        input logic [2:0] rgb,
        input coord_t     xc,
        input coord_t     yc,
        input logic       hs,
        input logic       vs,
        input logic       active
    );
        logic [STREAM_W-1:0] w;
        w                   = '0;
        w[RGB_MSB:RGB_LSB]  = rgb;
        w[XC_MSB:XC_LSB]    = xc;
        w[YC_MSB:YC_LSB]    = yc;
        w[HS_BIT]           = hs;
        w[VS_BIT]           = vs;
        w[ACTIVE_BIT]       = active;
        return w;
    endfunction

endpackage

// File: rtl/vga_stream_gen_sync_counter.sv
// Free-running 10-bit timing counter with active and sync window decode.
// Used once per axis; the vertical instance is stepped by the horizontal wrap.
module sync_counter
    import vga_stream_gen_pkg::*;
#(
    parameter int unsigned TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP,
    parameter int unsigned ACT_END    = DEF_H_ACTIVE,
    parameter int unsigned SYNC_START = DEF_H_ACTIVE + DEF_H_FP,
    parameter int unsigned SYNC_END   = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t count,
    output logic   wrap,
    output logic   in_active,
    output logic   in_sync
);

    localparam coord_t  LAST   = coord_t'(TOTAL - 1);
    localparam wcoord_t ACT_W  = wcoord_t'(ACT_END);
    localparam wcoord_t SS_W   = wcoord_t'(SYNC_START);
    localparam wcoord_t SE_W   = wcoord_t'(SYNC_END);

    wcoord_t count_w;

    // Wrap is qualified by the enable so the next stage sees a single strobe
    always_comb begin
        count_w   = {1'b0, count};
        wrap      = en && (count == LAST);
        in_active = (count_w < ACT_W);
        in_sync   = (count_w >= SS_W) && (count_w < SE_W);
    end

    // Count on enable, returning to zero after the last position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + coord_t'(1);
        end
    end

endmodule

// File: rtl/vga_stream_gen.sv
// VGA timing source producing the registered 26-bit RGB stream and a
// frame-start strobe aligned with the (0,0) word.
// Optional build macro: VGA_STREAM_TESTPATTERN_EN (colour bars with a white
// border ring inside the visible area instead of BG_COLOR).
module vga_stream_gen
    import vga_stream_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter logic [2:0]  BG_COLOR = 3'b000
) (
    input  logic                px_clk,
    input  logic                reset,
    output logic [STREAM_W-1:0] RGBStr_o,
    output logic                frame_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [STREAM_W-1:0] RESET_WORD =
        pack_stream(3'b000, '0, '0, ~HS_POL, ~VS_POL, 1'b0);

    if (H_TOTAL > MAX_TOTAL) begin : g_h_total_check
        $error("vga_stream_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_v_total_check
        $error("vga_stream_gen: V_TOTAL exceeds 1024");
    end

    coord_t              h_count;
    coord_t              v_count;
    logic                h_wrap;
    logic                v_wrap;
    logic                h_active;
    logic                v_active;
    logic                h_sync;
    logic                v_sync;
    logic                active;
    logic [2:0]          active_rgb;
    logic [2:0]          rgb_next;
    logic [STREAM_W-1:0] word_next;
    logic                at_origin;

    sync_counter #(
        .TOTAL      (H_TOTAL),
        .ACT_END    (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
    ) u_h_counter (
        .clk       (px_clk),
        .rst       (reset),
        .en        (1'b1),
        .count     (h_count),
        .wrap      (h_wrap),
        .in_active (h_active),
        .in_sync   (h_sync)
    );

    sync_counter #(
        .TOTAL      (V_TOTAL),
        .ACT_END    (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
    ) u_v_counter (
        .clk       (px_clk),
        .rst       (reset),
        .en        (h_wrap),
        .count     (v_count),
        .wrap      (v_wrap),
        .in_active (v_active),
        .in_sync   (v_sync)
    );

`ifdef VGA_STREAM_TESTPATTERN_EN
    logic ring;

    // Outermost visible row/column is forced white, elsewhere 128-pixel bars
    always_comb begin
        ring       = (h_count == '0) || (h_count == coord_t'(H_ACTIVE - 1)) ||
                     (v_count == '0) || (v_count == coord_t'(V_ACTIVE - 1));
        active_rgb = ring ? 3'b111 : h_count[9:7];
    end
`else
    // Flat background colour during the visible area
    always_comb begin
        active_rgb = BG_COLOR;
    end
`endif

    // Describe the current counter position as the next stream word
    always_comb begin
        active    = h_active && v_active;
        rgb_next  = active ? active_rgb : 3'b000;
        word_next = pack_stream(rgb_next, h_count, v_count,
                                h_sync ? HS_POL : ~HS_POL,
                                v_sync ? VS_POL : ~VS_POL,
                                active);
    end

    // Register the stream word; at_origin flags that the counters now sit at
    // (0,0), so frame_o lands on the same cycle as that word.
    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            RGBStr_o  <= RESET_WORD;
            frame_o   <= 1'b0;
            at_origin <= 1'b1;
        end else begin
            RGBStr_o  <= word_next;
            frame_o   <= at_origin;
            at_origin <= v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_stream_gen.sv
// Scoreboard bench for vga_stream_gen: a default-timing instance for line
// checks and a tiny-timing instance for full frames, wraps and mid-frame reset.
module tb_vga_stream_gen;

    typedef struct {
        logic [25:0] w;
        logic        f;
    } exp_t;

    typedef struct {
        int         inst;   // 0 = default timing, 1 = small timing
        int         k;      // words since reset release
        int         x;
        int         y;
        logic [2:0] rgb;
        bit         hs;
        bit         vs;
        bit         act;
        bit         fr;
    } dir_t;

`ifdef VGA_STREAM_TESTPATTERN_EN
    localparam logic [2:0] RING_D = 3'b111;
    localparam logic [2:0] BAR1_D = 3'b001;
    localparam logic [2:0] BAR4_D = 3'b100;
    localparam logic [2:0] RING_S = 3'b111;
    localparam logic [2:0] IN_S   = 3'b000;
`else
    localparam logic [2:0] RING_D = 3'b000;
    localparam logic [2:0] BAR1_D = 3'b000;
    localparam logic [2:0] BAR4_D = 3'b000;
    localparam logic [2:0] RING_S = 3'b101;
    localparam logic [2:0] IN_S   = 3'b101;
`endif

    // Reset words: default HS/VS active-low -> both 1; small HS active-high
    localparam logic [25:0] RST_D = 26'h0000006;
    localparam logic [25:0] RST_S = 26'h0000002;

    logic        px_clk = 1'b0;
    logic        rst    = 1'b1;
    logic [25:0] word_d, word_s;
    logic        frame_d, frame_s;

    exp_t qd[$];
    exp_t qs[$];
    dir_t dirs[$];

    int tests = 0;
    int fails = 0;
    int dx = 0, dy = 0, sx = 0, sy = 0;
    int k = 0;
    bit k_valid = 1'b0;

    always #5 px_clk = ~px_clk;

    vga_stream_gen dut_d (
        .px_clk   (px_clk),
        .reset    (rst),
        .RGBStr_o (word_d),
        .frame_o  (frame_d)
    );

    vga_stream_gen #(
        .H_ACTIVE (16),
        .H_FP     (4),
        .H_SYNC   (6),
        .H_BP     (6),
        .V_ACTIVE (6),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (2),
        .HS_POL   (1'b1),
        .VS_POL   (1'b0),
        .BG_COLOR (3'b101)
    ) dut_s (
        .px_clk   (px_clk),
        .reset    (rst),
        .RGBStr_o (word_s),
        .frame_o  (frame_s)
    );

    // Reference word for a raster position under the given timing
    function automatic logic [25:0] model(input int x, input int y,
                                          input int ha, input int hfp, input int hsw,
                                          input int va, input int vfp, input int vsw,
                                          input bit hp, input bit vp,
                                          input logic [2:0] bg);
        logic       act, hs, vs;
        logic [9:0] xv, yv;
        logic [2:0] rgb;
        xv  = 10'(x);
        yv  = 10'(y);
        act = (x < ha) && (y < va);
        hs  = (x >= ha + hfp && x < ha + hfp + hsw) ? hp : ~hp;
        vs  = (y >= va + vfp && y < va + vfp + vsw) ? vp : ~vp;
        rgb = 3'b000;
        if (act) begin
`ifdef VGA_STREAM_TESTPATTERN_EN
            if (x == 0 || x == ha - 1 || y == 0 || y == va - 1) rgb = 3'b111;
            else rgb = xv[9:7];
`else
            rgb = bg;
`endif
        end
        return {rgb, xv, yv, hs, vs, act};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0t k=%0d: got %h expected %h", name, $time, k, got, exp);
        end
    endtask

    // One px_clk edge: work out what each DUT must show after it, queue it
    task automatic tick(input bit mid_reset);
        exp_t ed, es;
        @(posedge px_clk);
        #1;
        if (rst) begin
            ed = '{RST_D, 1'b0};
            es = '{RST_S, 1'b0};
            dx = 0; dy = 0; sx = 0; sy = 0;
            k_valid = 1'b0;
        end else begin
            ed.w = model(dx, dy, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0, 3'b000);
            ed.f = (dx == 0 && dy == 0);
            es.w = model(sx, sy, 16, 4, 6, 6, 2, 2, 1'b1, 1'b0, 3'b101);
            es.f = (sx == 0 && sy == 0);
            dx++;
            if (dx == 800) begin dx = 0; dy++; if (dy == 525) dy = 0; end
            sx++;
            if (sx == 32) begin sx = 0; sy++; if (sy == 12) sy = 0; end
            k = k_valid ? k + 1 : 0;
            k_valid = 1'b1;
        end
        if (mid_reset) begin
            #1;
            rst = 1'b1;
            ed = '{RST_D, 1'b0};
            es = '{RST_S, 1'b0};
            dx = 0; dy = 0; sx = 0; sy = 0;
            k_valid = 1'b0;
        end
        qd.push_back(ed);
        qs.push_back(es);
    endtask

    // Monitor: compare each presented word against the scoreboard and table
    always @(negedge px_clk) begin
        exp_t e;
        logic [25:0] dw, got;
        if (qd.size() > 0) begin
            e = qd.pop_front();
            chk("word_d", {6'd0, word_d}, {6'd0, e.w});
            chk("frame_d", {31'd0, frame_d}, {31'd0, e.f});
        end
        if (qs.size() > 0) begin
            e = qs.pop_front();
            chk("word_s", {6'd0, word_s}, {6'd0, e.w});
            chk("frame_s", {31'd0, frame_s}, {31'd0, e.f});
        end
        if (k_valid) begin
            foreach (dirs[i]) begin
                if (dirs[i].k == k) begin
                    dw  = {dirs[i].rgb, 10'(dirs[i].x), 10'(dirs[i].y),
                           dirs[i].hs, dirs[i].vs, dirs[i].act};
                    got = (dirs[i].inst == 0) ? word_d : word_s;
                    chk((dirs[i].inst == 0) ? "dir_word_d" : "dir_word_s",
                        {6'd0, got}, {6'd0, dw});
                    chk((dirs[i].inst == 0) ? "dir_frame_d" : "dir_frame_s",
                        {31'd0, (dirs[i].inst == 0) ? frame_d : frame_s},
                        {31'd0, dirs[i].fr});
                end
            end
        end
    end

    initial begin
        // Default timing: first line and start of second line
        dirs.push_back('{0,    0,   0, 0, RING_D, 1, 1, 1, 1});
        dirs.push_back('{0,  639, 639, 0, RING_D, 1, 1, 1, 0});
        dirs.push_back('{0,  640, 640, 0, 3'b000, 1, 1, 0, 0});
        dirs.push_back('{0,  655, 655, 0, 3'b000, 1, 1, 0, 0});
        dirs.push_back('{0,  656, 656, 0, 3'b000, 0, 1, 0, 0});
        dirs.push_back('{0,  751, 751, 0, 3'b000, 0, 1, 0, 0});
        dirs.push_back('{0,  752, 752, 0, 3'b000, 1, 1, 0, 0});
        dirs.push_back('{0,  799, 799, 0, 3'b000, 1, 1, 0, 0});
        dirs.push_back('{0,  800,   0, 1, RING_D, 1, 1, 1, 0});
        dirs.push_back('{0,  805,   5, 1, 3'b000, 1, 1, 1, 0});
        dirs.push_back('{0,  930, 130, 1, BAR1_D, 1, 1, 1, 0});
        dirs.push_back('{0, 1320, 520, 1, BAR4_D, 1, 1, 1, 0});
        dirs.push_back('{0, 1439, 639, 1, RING_D, 1, 1, 1, 0});
        // Small timing 32x12: HS high on 20..25, VS low on lines 8..9
        dirs.push_back('{1,    0,   0,  0, RING_S, 0, 1, 1, 1});
        dirs.push_back('{1,   15,  15,  0, RING_S, 0, 1, 1, 0});
        dirs.push_back('{1,   16,  16,  0, 3'b000, 0, 1, 0, 0});
        dirs.push_back('{1,   19,  19,  0, 3'b000, 0, 1, 0, 0});
        dirs.push_back('{1,   20,  20,  0, 3'b000, 1, 1, 0, 0});
        dirs.push_back('{1,   25,  25,  0, 3'b000, 1, 1, 0, 0});
        dirs.push_back('{1,   26,  26,  0, 3'b000, 0, 1, 0, 0});
        dirs.push_back('{1,   32,   0,  1, RING_S, 0, 1, 1, 0});
        dirs.push_back('{1,   33,   1,  1, IN_S,   0, 1, 1, 0});
        dirs.push_back('{1,  192,   0,  6, 3'b000, 0, 1, 0, 0});
        dirs.push_back('{1,  255,  31,  7, 3'b000, 0, 1, 0, 0});
        dirs.push_back('{1,  256,   0,  8, 3'b000, 0, 0, 0, 0});
        dirs.push_back('{1,  319,  31,  9, 3'b000, 0, 0, 0, 0});
        dirs.push_back('{1,  320,   0, 10, 3'b000, 0, 1, 0, 0});
        dirs.push_back('{1,  383,  31, 11, 3'b000, 0, 1, 0, 0});
        dirs.push_back('{1,  384,   0,  0, RING_S, 0, 1, 1, 1});
        dirs.push_back('{1,  768,   0,  0, RING_S, 0, 1, 1, 1});

        repeat (5) tick(1'b0);
        #1 rst = 1'b0;
        repeat (1700) tick(1'b0);
        // Asynchronous reset asserted mid-cycle, partway through a frame
        tick(1'b1);
        repeat (3) tick(1'b0);
        #1 rst = 1'b0;
        repeat (900) tick(1'b0);
        @(negedge px_clk);
        #1;
        chk("queue_d_drained", qd.size(), 0);
        chk("queue_s_drained", qs.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
